rnf_txrsp: RTL
==============

Name: rnf_txrsp

Overview:
- Link-layer transmitter on the RN-F side of the CHI RSP channel.
- Accepts response flits from the RN-F protocol layer over a valid/ready handshake and drives TXRSPFLIT/TXRSPFLITV/TXRSPFLITPEND into the HN-F RXRSP receiver.
- Tracks the L-credits the receiver grants on TXRSPLCRDV and never sends a flit without a held credit.
- On link deactivation, returns all held credits using LCrdReturn flits.

Parameters:
- MAX_CREDITS, 4: maximum L-credits held; equals the receiver's RSP queue depth.
- RETURN_TGTID, 0: TgtID placed in generated LCrdReturn flits (HN-F node ID).
- CW, $clog2(MAX_CREDITS+1): credit counter width (derived).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- txrsp_flit  in  $bits(rspflit_t)  response flit from the protocol layer.
- txrsp_flit_valid  in  1  protocol-layer flit valid.
- txrsp_flit_ready  out  1  flit accepted this cycle when valid&ready.
- txrsp_deact_req  in  1  request link deactivation (level).
- txrsp_deact_done  out  1  all credits returned; link quiescent.
- TXRSPFLIT  out  $bits(rspflit_t)  flit to the receiver.
- TXRSPFLITV  out  1  flit valid.
- TXRSPFLITPEND  out  1  asserted the cycle before TXRSPFLITV.
- TXRSPLCRDV  in  1  one L-credit granted per high cycle.
- credit_count  out  CW  credits currently held.
- credit_overflow  out  1  sticky: a credit arrived while the count was at MAX_CREDITS.

Behaviour:
- Reset (reset low, asynchronous): credit_count=0, state=RUN, pipeline empty, TXRSPFLITV=0, TXRSPFLITPEND=0, TXRSPFLIT=0, txrsp_deact_done=0, credit_overflow=0, txrsp_flit_ready=0. Reset mid-transfer drops any in-flight flit; held credits are discarded.
- Two-stage pipeline:
  - Send decision at edge N loads the pend stage, so TXRSPFLITPEND=1 in cycle N+1.
  - The pend stage moves to the output stage at edge N+1, so TXRSPFLITV=1 with TXRSPFLIT in cycle N+2.
  - Back-to-back sends hold PEND and FLITV high continuously. Throughput is 1 flit/cycle.
- Send condition: credit_count>0 and a flit source is available:
  - RUN: the upstream flit.
  - DRAIN: a generated LCrdReturn.
- txrsp_flit_ready = (state==RUN) & (credit_count>0). This is combinational and does not depend on valid.
- Credit arithmetic, per cycle: next = count − send + TXRSPLCRDV.
  - Simultaneous send and grant: count is unchanged.
  - Grant at MAX_CREDITS with no send: count stays MAX_CREDITS and credit_overflow sets. It clears only on reset.
  - Count never underflows; no send occurs at 0.
- State machine:
  - RUN → DRAIN when txrsp_deact_req=1. Any flit accepted in the same cycle still completes.
  - DRAIN: txrsp_flit_ready=0. Each cycle with credit_count>0, send one LCrdReturn flit: Opcode=0x0, TgtID=RETURN_TGTID, all other fields 0. Each consumes one credit.
  - DRAIN → STOP when credit_count==0 and both pipeline stages are empty.
  - STOP: txrsp_deact_done=1 (registered, asserted in the first STOP cycle). Credits arriving in STOP are counted but not sent.
  - STOP → RUN when txrsp_deact_req=0. txrsp_deact_done falls in the first RUN cycle.
  - txrsp_deact_req deasserting during DRAIN is ignored until STOP is reached.
- Credits granted during DRAIN are also returned, so DRAIN exits only when the count reaches zero.
- TXRSPFLIT holds its last value when TXRSPFLITV=0.

Test Plan:
- Reset, then TXRSPLCRDV high 4 cycles with no traffic → credit_count=4, txrsp_flit_ready=1, credit_overflow=0. A 5th grant → credit_overflow=1, count stays 4.
- 4 credits held, 6 back-to-back upstream flits (TxnID 0..5), no further grants → TxnIDs 0..3 accepted. PEND high cycles N+1..N+4, FLITV high cycles N+2..N+5. ready=0 after the 4th accept; TxnID 4 stalls until a credit arrives.
- Credit count 1, upstream valid and TXRSPLCRDV high in the same cycle, repeated 10 cycles → one flit sent per cycle, credit_count stays 1.
- Credits=3, txrsp_deact_req=1 → 3 consecutive FLITV cycles with Opcode=0 and TgtID=RETURN_TGTID. txrsp_deact_done=1 two cycles after the last FLITV. Release req → ready returns when credits>0.
- Deact in DRAIN with 2 credits, one TXRSPLCRDV grant mid-drain → exactly 3 LCrdReturn flits before done.
- Reset pulsed low while PEND=1 → PEND, FLITV and credit_count return to 0 immediately (asynchronous). No FLITV afterwards.

Source files
------------

// File: rtl/rnf_txrsp.sv
// RN-F CHI RSP link-layer transmitter: credit-gated two-stage flit pipeline
// with LCrdReturn generation to hand back all held L-credits on deactivation.

package rnf_txrsp_pkg;

  typedef struct packed {
    logic [3:0] qos;
    logic [6:0] tgt_id;
    logic [6:0] src_id;
    logic [7:0] txn_id;
    logic [3:0] opcode;
    logic [1:0] resp_err;
    logic [2:0] resp;
    logic [2:0] fwd_state;
    logic [7:0] dbid;
    logic [3:0] pcrd_type;
    logic       trace_tag;
  } rspflit_t;

  localparam logic [3:0] RSP_LCRDRETURN = 4'h0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_STOP  = 2'd2
  } state_t;

endpackage

module rnf_txrsp
  import rnf_txrsp_pkg::*;
#(
  parameter int         MAX_CREDITS  = 4,
  parameter logic [6:0] RETURN_TGTID = 7'h00,
  parameter int         CW           = $clog2(MAX_CREDITS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [$bits(rspflit_t)-1:0] txrsp_flit,
  input  logic                  txrsp_flit_valid,
  output logic                  txrsp_flit_ready,
  input  logic                  txrsp_deact_req,
  output logic                  txrsp_deact_done,
  output logic [$bits(rspflit_t)-1:0] TXRSPFLIT,
  output logic                  TXRSPFLITV,
  output logic                  TXRSPFLITPEND,
  input  logic                  TXRSPLCRDV,
  output logic [CW-1:0]         credit_count,
  output logic                  credit_overflow
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CREDITS);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  state_t        state, state_next;
  logic [CW-1:0] count_q, count_next;
  logic          overflow_q, overflow_set;
  logic          done_q;

  logic          pend_valid, out_valid;
  rspflit_t      pend_flit, out_flit;

  logic          have_credit;
  logic          send;
  rspflit_t      lcrd_flit;
  rspflit_t      send_flit;

  assign have_credit = (count_q != '0);

  // A send needs a held credit and a source: upstream in RUN, a generated
  // LCrdReturn in DRAIN. STOP never sends, even if credits trickle in.
  always_comb begin
    lcrd_flit        = '0;
    lcrd_flit.opcode = RSP_LCRDRETURN;
    lcrd_flit.tgt_id = RETURN_TGTID;
  end

  always_comb begin
    // NOTE: every signal driven from always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    send      = 1'b0;
    send_flit = rspflit_t'(txrsp_flit);
    case (state)
      ST_RUN:   send = have_credit & txrsp_flit_valid;
      ST_DRAIN: begin
        send      = have_credit;
        send_flit = lcrd_flit;
      end
      default:  send = 1'b0;
    endcase
  end

  // Credit arithmetic: next = count - send + grant, saturating at MAX.
  always_comb begin
    count_next   = count_q;
    overflow_set = 1'b0;
    case ({send, TXRSPLCRDV})
      2'b10: count_next = count_q - ONE_CNT;
      2'b01: begin
        if (count_q == MAX_CNT) overflow_set = 1'b1;
        else                    count_next   = count_q + ONE_CNT;
      end
      default: count_next = count_q;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) state <= ST_RUN;
    else        state <= state_next;
  end

  // Next-state logic. DRAIN also waits out a same-cycle grant so that no
  // credit is stranded when the link goes quiescent.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (txrsp_deact_req) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!have_credit && !TXRSPLCRDV && !pend_valid && !out_valid)
          state_next = ST_STOP;
      end
      ST_STOP: begin
        if (!txrsp_deact_req) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    txrsp_flit_ready = (state == ST_RUN) & have_credit;
    txrsp_deact_done = done_q;
    credit_count     = count_q;
    credit_overflow  = overflow_q;
    TXRSPFLITPEND    = pend_valid;
    TXRSPFLITV       = out_valid;
    TXRSPFLIT        = out_flit;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      count_q    <= count_next;
      overflow_q <= overflow_q | overflow_set;
      done_q     <= (state_next == ST_STOP);
    end
  end

  // Pend stage feeds the output stage one cycle later; the output flit is
  // only reloaded when a flit advances, so it holds while FLITV is low.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: the flit payload registers are reset too because TXRSPFLIT is a
    // visible output with a defined value out of reset.
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_flit  <= '0;
      out_valid  <= 1'b0;
      out_flit   <= '0;
    end else begin
      pend_valid <= send;
      if (send) pend_flit <= send_flit;
      out_valid  <= pend_valid;
      if (pend_valid) out_flit <= pend_flit;
    end
  end

endmodule
